// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run controller.
package mips_run_pkg;

   // Controller phases: stream program, hold core in reset, run, drain, finished.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      HOLD  = 3'd2,
      RUN   = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } run_state_e;

   // Width of the HOLD/DRAIN phase counter; bounds RESET_CYCLES and DRAIN_CYCLES.
   localparam int PHASE_W = 16;

   // Default instruction encoding treated as a halt.
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   // Debug view of the controller FSM.
   typedef struct packed {
      run_state_e           state;
      logic [PHASE_W-1:0]   phase_count;
   } run_dbg_t;

   // Word-address width for an instruction memory of the given depth (at least 1 bit).
   function automatic int addr_width(input int depth);
      if (depth <= 2) return 1;
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mips_run_cnt.sv
// Generic up-counter with synchronous clear, parallel load, enable,
// saturation at all-ones and a terminal-count flag.
module mips_run_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] count,
   output logic         tc
);

   // Clear beats load beats increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == terminal);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: streams a program into
// instruction memory, holds the core in reset, runs it and ends the run
// on a halt fetch (after a pipeline drain) or on a cycle budget.
//
// Load handshake: a word transfers on every rising clk edge where
// load_valid && load_ready. load_ready depends only on the FSM state, so
// the source may hold load_valid high for any number of cycles and the
// word/last fields must stay stable until the transfer edge.
module mips_run_ctrl
   import mips_run_pkg::*;
#(
   parameter int                    WORD_WIDTH   = 32,
   parameter int                    IMEM_DEPTH   = 1024,
   parameter int                    RESET_CYCLES = 1,
   parameter int                    MAX_CYCLES   = 75,
   parameter int                    DRAIN_CYCLES = 4,
   parameter int                    CNT_WIDTH    = 16,
   parameter logic [WORD_WIDTH-1:0] HALT_WORD    = WORD_WIDTH'(DEFAULT_HALT_WORD),
   localparam int                   ADDR_W       = addr_width(IMEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  load_valid,
   input  logic [WORD_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  imem_we,
   output logic [ADDR_W-1:0]     imem_addr,
   output logic [WORD_WIDTH-1:0] imem_wdata,
   output logic                  core_reset_n,
   input  logic [WORD_WIDTH-1:0] instruction,
   input  logic                  IF_Flush,
   output logic [CNT_WIDTH-1:0]  run_cycles,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic                  load_err,
   output run_dbg_t              dbg
);

   localparam logic [PHASE_W-1:0]   HOLD_TC  = PHASE_W'(RESET_CYCLES - 1);
   localparam logic [PHASE_W-1:0]   DRAIN_TC = PHASE_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RUN_TC   = CNT_WIDTH'(MAX_CYCLES - 1);
   localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(IMEM_DEPTH - 1);

   run_state_e          state;
   run_state_e          next_state;
   logic [ADDR_W-1:0]   word_idx;
   logic [PHASE_W-1:0]  phase_count;
   logic [PHASE_W-1:0]  phase_terminal;
   logic                phase_tc;
   logic                run_tc;
   logic                accept;
   logic                start_ok;
   logic                halt_seen;
   logic                load_end;

   assign accept    = load_valid && load_ready;
   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign halt_seen = (instruction == HALT_WORD) && !IF_Flush;
   assign load_end  = accept && (load_last || (word_idx == LAST_IDX));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; a halt in the last budget cycle still goes to DRAIN.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = LOAD;
         LOAD:       if (load_end) next_state = HOLD;
         HOLD:       if (phase_tc) next_state = RUN;
         RUN: begin
            if (halt_seen)   next_state = DRAIN;
            else if (run_tc) next_state = DONE;
         end
         DRAIN:      if (phase_tc) next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   // Moore outputs decoded straight from the state flops; the core stays
   // out of reset in DONE so its state can be inspected.
   always_comb begin
      load_ready   = (state == LOAD);
      busy         = (state == LOAD) || (state == HOLD) ||
                     (state == RUN)  || (state == DRAIN);
      done         = (state == DONE);
      core_reset_n = (state == RUN) || (state == DRAIN) || (state == DONE);
   end

   // Load datapath and sticky flags; writes land one cycle after the accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         timeout    <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= accept;
         if (accept) begin
            imem_addr  <= word_idx;
            imem_wdata <= load_data;
            word_idx   <= word_idx + 1'b1;
            if (!load_last && (word_idx == LAST_IDX)) load_err <= 1'b1;
         end
         if ((state == RUN) && !halt_seen && run_tc) timeout <= 1'b1;
         if (start_ok) begin
            word_idx <= '0;
            timeout  <= 1'b0;
            load_err <= 1'b0;
         end
      end
   end

   // Shared HOLD/DRAIN phase counter, restarted on every state change.
   assign phase_terminal = (state == HOLD) ? HOLD_TC : DRAIN_TC;

   mips_run_cnt #(.W(PHASE_W)) u_phase_cnt (
      .clk        (clk),
      .clear      (reset),
      .load       (next_state != state),
      .load_value ('0),
      .enable     ((state == HOLD) || (state == DRAIN)),
      .terminal   (phase_terminal),
      .count      (phase_count),
      .tc         (phase_tc)
   );

   // Run-cycle counter: cleared by a new start, frozen outside RUN/DRAIN.
   mips_run_cnt #(.W(CNT_WIDTH)) u_run_cnt (
      .clk        (clk),
      .clear      (reset),
      .load       (start_ok),
      .load_value ('0),
      .enable     ((state == RUN) || (state == DRAIN)),
      .terminal   (RUN_TC),
      .count      (run_cycles),
      .tc         (run_tc)
   );

   assign dbg.state       = state;
   assign dbg.phase_count = phase_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl (IMEM_DEPTH=8, other parameters default).
module tb_mips_run_ctrl;
   import mips_run_pkg::*;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        imem_we;
   logic [2:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset_n;
   logic [31:0] instruction;
   logic        IF_Flush;
   logic [15:0] run_cycles;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        load_err;
   run_dbg_t    dbg;

   int passed = 0;
   int total  = 0;

   mips_run_ctrl #(.IMEM_DEPTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset_n (core_reset_n),
      .instruction  (instruction),
      .IF_Flush     (IF_Flush),
      .run_cycles   (run_cycles),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .load_err     (load_err),
      .dbg          (dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Presents one word for a single cycle and checks the write it produces.
   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] addr);
      chk("ready_before_word", load_ready, 1'b1);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      cycle();
      load_valid = 1'b0;
      load_last  = 1'b0;
      chk("imem_we", imem_we, 1'b1);
      chk("imem_addr", imem_addr, addr);
      chk("imem_wdata", imem_wdata, d);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
      load_last = 1'b0; instruction = '0; IF_Flush = 1'b0;
      repeat (2) cycle();
      reset = 1'b0;
      chk("por_state", dbg.state, IDLE);
      chk("por_core_reset_n", core_reset_n, 1'b0);
      chk("por_load_ready", load_ready, 1'b0);
      chk("por_busy", busy, 1'b0);

      // Reset in the middle of a load.
      do_start();
      chk("t1_state_load", dbg.state, LOAD);
      send_word(32'h1111_0000, 1'b0, 3'd0);
      send_word(32'h1111_0001, 1'b0, 3'd1);
      send_word(32'h1111_0002, 1'b0, 3'd2);
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      chk("t1_state", dbg.state, IDLE);
      chk("t1_core_reset_n", core_reset_n, 1'b0);
      chk("t1_imem_we", imem_we, 1'b0);
      chk("t1_imem_addr", imem_addr, 3'd0);
      chk("t1_flags", {busy, done, timeout, load_err, load_ready}, 5'b0);
      chk("t1_run_cycles", run_cycles, 16'd0);

      // Four-word program ending in a halt.
      do_start();
      chk("t2_busy", busy, 1'b1);
      send_word(32'h2008_0005, 1'b0, 3'd0);
      send_word(32'h2009_0003, 1'b0, 3'd1);
      send_word(32'h0109_5020, 1'b0, 3'd2);
      send_word(HALT,          1'b1, 3'd3);
      chk("t2_hold_state", dbg.state, HOLD);
      chk("t2_hold_core_reset_n", core_reset_n, 1'b0);
      chk("t2_hold_ready", load_ready, 1'b0);
      cycle();
      chk("t2_run_state", dbg.state, RUN);
      chk("t2_core_released", core_reset_n, 1'b1);
      chk("t2_we_idle", imem_we, 1'b0);
      chk("t2_run_start", run_cycles, 16'd0);
      instruction = 32'h2008_0005;
      repeat (4) cycle();
      chk("t2_run_cycles_4", run_cycles, 16'd4);
      instruction = HALT;
      cycle();
      chk("t2_drain_state", dbg.state, DRAIN);
      repeat (3) cycle();
      chk("t2_drain_busy", {busy, done}, 2'b10);
      cycle();
      instruction = '0;
      chk("t2_done", done, 1'b1);
      chk("t2_timeout", timeout, 1'b0);
      chk("t2_run_cycles", run_cycles, 16'd9);
      chk("t2_busy_done", busy, 1'b0);
      repeat (2) cycle();
      chk("t2_frozen", run_cycles, 16'd9);
      chk("t2_core_kept", core_reset_n, 1'b1);

      // No halt: the cycle budget ends the run.
      do_start();
      chk("t3_restart_core", core_reset_n, 1'b0);
      chk("t3_cleared", {done, timeout, load_err}, 3'b0);
      chk("t3_run_cleared", run_cycles, 16'd0);
      send_word(32'h2008_0005, 1'b0, 3'd0);
      send_word(32'h0000_0000, 1'b1, 3'd1);
      cycle();
      repeat (74) cycle();
      chk("t3_run_74", run_cycles, 16'd74);
      chk("t3_still_run", dbg.state, RUN);
      cycle();
      chk("t3_done", done, 1'b1);
      chk("t3_timeout", timeout, 1'b1);
      chk("t3_run_cycles", run_cycles, 16'd75);
      chk("t3_core_kept", core_reset_n, 1'b1);
      cycle();
      chk("t3_frozen", run_cycles, 16'd75);

      // Overflow of an 8-word memory, then a flushed and an unflushed halt.
      do_start();
      for (int i = 0; i < 8; i++) send_word(32'hA000_0000 + 32'(i), 1'b0, 3'(i));
      chk("t4_load_err", load_err, 1'b1);
      chk("t4_hold", dbg.state, HOLD);
      load_valid = 1'b1;
      load_data  = 32'hA000_0008;
      chk("t4_ninth_not_ready", load_ready, 1'b0);
      cycle();
      load_valid = 1'b0;
      chk("t4_ninth_not_written", imem_we, 1'b0);
      chk("t4_run", dbg.state, RUN);
      instruction = HALT;
      IF_Flush    = 1'b1;
      cycle();
      chk("t5_flushed_halt_state", dbg.state, RUN);
      chk("t5_flushed_run_cycles", run_cycles, 16'd1);
      IF_Flush = 1'b0;
      cycle();
      instruction = '0;
      chk("t5_unflushed_halt", dbg.state, DRAIN);
      repeat (4) cycle();
      chk("t4_done", done, 1'b1);
      chk("t4_timeout", timeout, 1'b0);
      chk("t4_run_cycles", run_cycles, 16'd6);
      chk("t4_load_err_held", load_err, 1'b1);

      // Halt in the final budget cycle wins over the timeout.
      do_start();
      chk("t5_load_err_cleared", load_err, 1'b0);
      send_word(32'h0000_0000, 1'b1, 3'd0);
      cycle();
      repeat (74) cycle();
      chk("t5_run_74", run_cycles, 16'd74);
      instruction = HALT;
      cycle();
      chk("t5_edge_drain", dbg.state, DRAIN);
      chk("t5_edge_not_done", done, 1'b0);
      repeat (4) cycle();
      instruction = '0;
      chk("t5_edge_done", done, 1'b1);
      chk("t5_edge_timeout", timeout, 1'b0);
      chk("t5_edge_run_cycles", run_cycles, 16'd79);

      // Backpressure gaps, start ignored in RUN, restart from DONE.
      do_start();
      send_word(32'hB000_0000, 1'b0, 3'd0);
      cycle();
      chk("t6_gap1_we", imem_we, 1'b0);
      send_word(32'hB000_0001, 1'b0, 3'd1);
      repeat (3) cycle();
      chk("t6_gap2_we", imem_we, 1'b0);
      chk("t6_gap2_state", dbg.state, LOAD);
      send_word(32'hB000_0002, 1'b1, 3'd2);
      cycle();
      chk("t6_run", dbg.state, RUN);
      do_start();
      chk("t6_start_ignored", dbg.state, RUN);
      chk("t6_run_cycles", run_cycles, 16'd1);
      chk("t6_core_stays", core_reset_n, 1'b1);
      instruction = HALT;
      cycle();
      instruction = '0;
      repeat (4) cycle();
      chk("t6_done", done, 1'b1);
      chk("t6_done_cycles", run_cycles, 16'd6);
      do_start();
      chk("t6_reload_state", dbg.state, LOAD);
      chk("t6_reload_core", core_reset_n, 1'b0);
      chk("t6_reload_flags", {done, timeout, load_err}, 3'b0);
      chk("t6_reload_cycles", run_cycles, 16'd0);
      send_word(32'hC000_0000, 1'b1, 3'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
